// File: rtl/morra_tabellone.sv
// Purpose: scoreboard for the Morra Cinese core; tallies manche and partite and decides the tournament winner.
// Latency: one cycle; a result sampled on an edge is visible on the outputs right after that edge.
// Backpressure: none; VALIDO is a one-cycle strobe and every strobe is consumed or deliberately ignored.
module morra_tabellone #(
    parameter int W_MANCHE   = 5,
    parameter int W_PARTITE  = 4,
    parameter int MAX_MANCHE = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 INIZIA,
    input  logic [W_PARTITE-1:0] NUM_PARTITE,
    input  logic                 VALIDO,
    input  logic [1:0]           MANCHE,
    input  logic [1:0]           PARTITA,
    output logic [W_MANCHE-1:0]  MANCHE_GIOCATE,
    output logic [W_MANCHE-1:0]  VINTE_PRIMO,
    output logic [W_MANCHE-1:0]  VINTE_SECONDO,
    output logic [W_PARTITE-1:0] PARTITE_GIOCATE,
    output logic [W_PARTITE-1:0] PARTITE_PRIMO,
    output logic [W_PARTITE-1:0] PARTITE_SECONDO,
    output logic [1:0]           STATO,
    output logic [1:0]           VINCITORE,
    output logic                 FINE,
    output logic                 ERRORE
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_GIOCO = 2'b01,
        S_FINE  = 2'b10
    } stato_t;

    localparam logic [W_MANCHE-1:0]  MAX_M     = W_MANCHE'(MAX_MANCHE);
    localparam logic [W_MANCHE-1:0]  MAX_M_M1  = W_MANCHE'(MAX_MANCHE - 1);
    localparam logic [W_PARTITE-1:0] UNO_P     = W_PARTITE'(1);

    stato_t               stato_q,  stato_d;
    logic [W_MANCHE-1:0]  m_gioc_q, m_gioc_d;
    logic [W_MANCHE-1:0]  m_p1_q,   m_p1_d;
    logic [W_MANCHE-1:0]  m_p2_q,   m_p2_d;
    logic [W_PARTITE-1:0] p_gioc_q, p_gioc_d;
    logic [W_PARTITE-1:0] p_p1_q,   p_p1_d;
    logic [W_PARTITE-1:0] p_p2_q,   p_p2_d;
    logic [W_PARTITE-1:0] target_q, target_d;
    logic [1:0]           vinc_q,   vinc_d;
    logic                 err_q,    err_d;
    logic [W_PARTITE-1:0] half;

    // Saturating increments: never wrap, the caller flags the overflow.
    function automatic logic [W_MANCHE-1:0] inc_m(input logic [W_MANCHE-1:0] v);
        return (&v) ? v : v + W_MANCHE'(1);
    endfunction

    function automatic logic [W_PARTITE-1:0] inc_p(input logic [W_PARTITE-1:0] v);
        return (&v) ? v : v + UNO_P;
    endfunction

    assign half = target_q >> 1;

    // Next-state and next-counter logic; every value holds unless an event changes it.
    always_comb begin
        stato_d  = stato_q;
        m_gioc_d = m_gioc_q;
        m_p1_d   = m_p1_q;
        m_p2_d   = m_p2_q;
        p_gioc_d = p_gioc_q;
        p_p1_d   = p_p1_q;
        p_p2_d   = p_p2_q;
        target_d = target_q;
        vinc_d   = vinc_q;
        err_d    = err_q;

        if (INIZIA) begin
            // Restart wins over any result strobed in the same cycle.
            stato_d  = S_GIOCO;
            m_gioc_d = '0;
            m_p1_d   = '0;
            m_p2_d   = '0;
            p_gioc_d = '0;
            p_p1_d   = '0;
            p_p2_d   = '0;
            target_d = (NUM_PARTITE == '0) ? UNO_P : NUM_PARTITE;
            vinc_d   = 2'b00;
            err_d    = 1'b0;
        end else if (VALIDO) begin
            unique case (stato_q)
                S_IDLE: err_d = 1'b1;
                S_GIOCO: begin
                    if (PARTITA != 2'b00) begin
                        // Partita concluded: this round's manche result is dropped.
                        m_gioc_d = '0;
                        m_p1_d   = '0;
                        m_p2_d   = '0;
                        p_gioc_d = inc_p(p_gioc_q);
                        if (&p_gioc_q) err_d = 1'b1;
                        if (PARTITA == 2'b01) begin
                            p_p1_d = inc_p(p_p1_q);
                            if (&p_p1_q) err_d = 1'b1;
                        end
                        if (PARTITA == 2'b10) begin
                            p_p2_d = inc_p(p_p2_q);
                            if (&p_p2_q) err_d = 1'b1;
                        end
                    end else if (MANCHE != 2'b00) begin
                        // A manche counts only while below the per-partita ceiling.
                        if (m_gioc_q < MAX_M) begin
                            if (MANCHE == 2'b01) begin
                                m_p1_d = inc_m(m_p1_q);
                                if (&m_p1_q) err_d = 1'b1;
                            end
                            if (MANCHE == 2'b10) begin
                                m_p2_d = inc_m(m_p2_q);
                                if (&m_p2_q) err_d = 1'b1;
                            end
                        end
                        if (m_gioc_q >= MAX_M_M1) begin
                            m_gioc_d = MAX_M;
                            err_d    = 1'b1;
                        end else begin
                            m_gioc_d = inc_m(m_gioc_q);
                            if (&m_gioc_q) err_d = 1'b1;
                        end
                    end

                    // Tournament end is judged on the values this edge will store.
                    if ((p_gioc_d == target_q) || (p_p1_d > half) || (p_p2_d > half)) begin
                        stato_d = S_FINE;
                        if (p_p1_d > p_p2_d)      vinc_d = 2'b01;
                        else if (p_p2_d > p_p1_d) vinc_d = 2'b10;
                        else                      vinc_d = 2'b11;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and counter registers, cleared immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stato_q  <= S_IDLE;
            m_gioc_q <= '0;
            m_p1_q   <= '0;
            m_p2_q   <= '0;
            p_gioc_q <= '0;
            p_p1_q   <= '0;
            p_p2_q   <= '0;
            target_q <= UNO_P;
            vinc_q   <= 2'b00;
            err_q    <= 1'b0;
        end else begin
            stato_q  <= stato_d;
            m_gioc_q <= m_gioc_d;
            m_p1_q   <= m_p1_d;
            m_p2_q   <= m_p2_d;
            p_gioc_q <= p_gioc_d;
            p_p1_q   <= p_p1_d;
            p_p2_q   <= p_p2_d;
            target_q <= target_d;
            vinc_q   <= vinc_d;
            err_q    <= err_d;
        end
    end

    assign MANCHE_GIOCATE  = m_gioc_q;
    assign VINTE_PRIMO     = m_p1_q;
    assign VINTE_SECONDO   = m_p2_q;
    assign PARTITE_GIOCATE = p_gioc_q;
    assign PARTITE_PRIMO   = p_p1_q;
    assign PARTITE_SECONDO = p_p2_q;
    assign STATO           = stato_q;
    assign VINCITORE       = vinc_q;
    assign FINE            = (stato_q == S_FINE);
    assign ERRORE          = err_q;

endmodule

// File: doc/morra_tabellone.md
Name: morra_tabellone

Overview:
Downstream scoreboard for the Morra Cinese game core. Consumes the per-manche result (MANCHE) and per-partita result (PARTITA) produced each round. Keeps manche and partita tallies for both players and decides the tournament winner once the configured number of partite is settled. Drives the display and status outputs of the game.

Parameters:
W_MANCHE, 5, width of manche counters
W_PARTITE, 4, width of partita counters and NUM_PARTITE
MAX_MANCHE, 20, manche in one partita after which an unresolved partita is an error

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
INIZIA  input  1  start/restart tournament; samples NUM_PARTITE
NUM_PARTITE  input  W_PARTITE  number of partite in the tournament; 0 is treated as 1
VALIDO  input  1  one-cycle strobe: MANCHE/PARTITA carry a new round result
MANCHE  input  2  00 annullata, 01 primo, 10 secondo, 11 pareggio
PARTITA  input  2  00 in corso, 01 primo, 10 secondo, 11 pareggio
MANCHE_GIOCATE  output  W_MANCHE  valid manche in the current partita
VINTE_PRIMO  output  W_MANCHE  manche won by player 1 in the current partita
VINTE_SECONDO  output  W_MANCHE  manche won by player 2 in the current partita
PARTITE_GIOCATE  output  W_PARTITE  partite concluded
PARTITE_PRIMO  output  W_PARTITE  partite won by player 1
PARTITE_SECONDO  output  W_PARTITE  partite won by player 2
STATO  output  2  00 IDLE, 01 GIOCO, 10 FINE
VINCITORE  output  2  00 none, 01 primo, 10 secondo, 11 pareggio
FINE  output  1  high while in FINE
ERRORE  output  1  sticky protocol/overflow error

Behaviour:
- Reset (rst_n low, asynchronous):
  - All counters 0.
  - STATO=IDLE, VINCITORE=00, FINE=0, ERRORE=0, stored target=1.
- All outputs are registered. A sampled event is visible the cycle after the capturing edge.
- INIZIA=1 at an edge, in any state:
  - Clear all counters, VINCITORE and ERRORE.
  - Load target = (NUM_PARTITE==0 ? 1 : NUM_PARTITE).
  - Go to GIOCO.
  - INIZIA has priority; VALIDO in the same cycle is ignored.
- IDLE:
  - VALIDO=1 sets ERRORE and changes nothing else.
  - INIZIA leaves IDLE.
- GIOCO, edge with VALIDO=1:
  - MANCHE=00: no counter change (annulled manche); PARTITA is still evaluated.
  - MANCHE=01/10/11: MANCHE_GIOCATE+1. Additionally, 01 → VINTE_PRIMO+1; 10 → VINTE_SECONDO+1; 11 → no per-player change.
  - PARTITA≠00 (partita concluded):
    - PARTITE_GIOCATE+1. Additionally, 01 → PARTITE_PRIMO+1; 10 → PARTITE_SECONDO+1; 11 → no per-player change.
    - All three manche counters clear to 0 on the same edge; the MANCHE update of that cycle is discarded.
  - No PARTITA and MANCHE_GIOCATE would reach MAX_MANCHE: ERRORE=1, counters hold at MAX_MANCHE, state stays GIOCO.
- Tournament end, evaluated on post-update values of the same edge. End occurs when any of these holds:
  - PARTITE_GIOCATE == target;
  - PARTITE_PRIMO > target/2 (integer division);
  - PARTITE_SECONDO > target/2.
  - On end: next STATO=FINE, FINE=1. VINCITORE = player with more partite, 11 if equal.
- FINE: VALIDO is ignored (no error). All values hold until INIZIA or reset.
- VALIDO=0: no change in any state.
- Counters never wrap. Increments saturate at the all-ones value and set ERRORE.
- ERRORE is sticky. It clears only on INIZIA or reset and does not affect counting.
- Reset asserted mid-partita: immediate clear, no completion of the in-flight update.

Test Plan:
- Reset then INIZIA with NUM_PARTITE=3 → STATO=01, all counters 0, ERRORE=0, FINE=0.
- Three VALIDO: MANCHE=01, 10, 11 with PARTITA=00 → MANCHE_GIOCATE=3, VINTE_PRIMO=1, VINTE_SECONDO=1.
- VALIDO with MANCHE=00, PARTITA=00 → no counter change. Next VALIDO with MANCHE=01, PARTITA=01 → PARTITE_PRIMO=1, PARTITE_GIOCATE=1, manche counters 0.
- Target=3; player 2 wins two partite (PARTITA=10 twice) → after the second, STATO=10, FINE=1, VINCITORE=10. A further VALIDO changes nothing.
- Target=2; PARTITA=01 then PARTITA=10 → PARTITE_GIOCATE=2, FINE=1, VINCITORE=11.
- VALIDO in IDLE → ERRORE=1, then INIZIA clears it. In GIOCO, 20 VALIDO with MANCHE=11 and no PARTITA → ERRORE=1, MANCHE_GIOCATE=20. rst_n pulse mid-sequence → all outputs 0 asynchronously.
